// File: rtl/pipe_shifter_if.sv
// pipe_shifter_if: valid/ready stream into and out of the pipelined shifter.
interface pipe_shifter_if #(
    parameter int WIDTH = 24,
    parameter int SHW = 5
);
    logic in_valid, in_ready, dir, out_valid, out_ready, sticky;
    logic [WIDTH-1:0] din, dout;
    logic [SHW-1:0] shamt;
    modport master(output in_valid, din, shamt, dir, out_ready, input in_ready, out_valid, dout, sticky);
    modport slave(input in_valid, din, shamt, dir, out_ready, output in_ready, out_valid, dout, sticky);
endinterface

// File: rtl/pipe_shifter.sv
// pipe_shifter: SHW-stage logarithmic shifter with sticky bit and valid/ready flow control.
module pipe_shifter #(
    parameter int WIDTH = 24,
    parameter int SHW = 5
) (
    input logic clk,
    input logic rst,
    pipe_shifter_if.slave bus
);
    localparam logic [WIDTH-1:0] ONES = '1;
    logic en;
    assign en = !g[SHW-1].v || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = g[SHW-1].v;
    assign bus.dout = g[SHW-1].d;
    assign bus.sticky = g[SHW-1].s;
    for (genvar k = 0; k < SHW; k++) begin : g
        localparam int A = 1 << k;
        localparam int N = SHW - k;
        logic [WIDTH-1:0] pd, nd, lost, d;
        logic [N-1:0] psh;
        logic ps, pv, pdir, s, v;
        if (k == 0) begin : g_in
            assign pd = bus.din;
            assign ps = 1'b0;
            assign pv = bus.in_valid;
            assign pdir = bus.dir;
            assign psh = bus.shamt;
        end else begin : g_in
            assign pd = g[k-1].d;
            assign ps = g[k-1].s;
            assign pv = g[k-1].v;
            assign pdir = g[k-1].g_sh.rdir;
            assign psh = g[k-1].g_sh.rsh;
        end
        assign nd = psh[0] ? (pdir ? pd >> A : pd << A) : pd;
        // bits that fall off the word: low end for right shifts, high end for left
        assign lost = psh[0] ? pd & (pdir ? ~(ONES << A) : ~(ONES >> A)) : '0;
        always_ff @(posedge clk) begin
            if (rst) begin
                v <= 1'b0;
                s <= 1'b0;
                d <= '0;
            end else if (en) begin
                v <= pv;
                s <= ps | (|lost);
                d <= nd;
            end
        end
        if (k < SHW - 1) begin : g_sh
            logic [N-2:0] rsh;
            logic rdir;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rsh <= '0;
                    rdir <= 1'b0;
                end else if (en) begin
                    rsh <= psh[N-1:1];
                    rdir <= pdir;
                end
            end
        end
    end
endmodule
